// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension block: MIPS opcodes,
// extension-mode encoding and control FSM states.
package imm_ext_pkg;

    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'b00,
        MODE_SIGN   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } imm_mode_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_HOLD_LUI = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/imm_ext_ctrl_if.sv
// Instruction-in / extended-immediate-out handshake bundle.
interface imm_ext_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [1:0]  out_mode;
    logic [4:0]  out_rt;
    logic        out_fused;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_mode, out_rt, out_fused
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_mode, out_rt, out_fused
    );
endinterface

// File: rtl/imm_ext_unit.sv
// Combinational opcode decode and 16->32 bit immediate extension.
module imm_ext_unit
    import imm_ext_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [15:0] imm16,
    output logic [31:0] imm32,
    output imm_mode_e   mode
);

    function automatic logic [31:0] ext_zero(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

    function automatic logic [31:0] ext_sign(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] ext_upper(input logic [15:0] v);
        return {v, 16'h0000};
    endfunction

    function automatic logic [31:0] ext_branch(input logic [15:0] v);
        return {{14{v[15]}}, v, 2'b00};
    endfunction

    // Unknown opcodes yield a zero immediate in zero mode.
    always_comb begin
        imm32 = 32'h0000_0000;
        mode  = MODE_ZERO;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: begin
                imm32 = ext_zero(imm16);
                mode  = MODE_ZERO;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                imm32 = ext_sign(imm16);
                mode  = MODE_SIGN;
            end
            OP_LUI: begin
                imm32 = ext_upper(imm16);
                mode  = MODE_UPPER;
            end
            OP_BEQ, OP_BNE: begin
                imm32 = ext_branch(imm16);
                mode  = MODE_BRANCH;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_ext_ctrl.sv
// Immediate-extension stage with a 1-cycle registered output and
// valid/ready handshake. Define IMM_FUSE_EN to fuse LUI+ORI into one result.
module imm_ext_ctrl
    import imm_ext_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_ext_ctrl_if.slave bus
);

    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic [31:0] ext_imm;
    imm_mode_e   ext_mode;

    assign opcode = bus.in_instr[31:26];
    assign rt     = bus.in_instr[20:16];
    assign imm16  = bus.in_instr[15:0];

    imm_ext_unit u_ext (
        .opcode (opcode),
        .imm16  (imm16),
        .imm32  (ext_imm),
        .mode   (ext_mode)
    );

    logic        vld_p1;
    logic [31:0] imm_p1;
    logic [1:0]  mode_p1;
    logic [4:0]  rt_p1;
    logic        fused_p1;

    logic        out_free;
    logic        in_ready;
    logic        load;
    logic [31:0] nxt_imm;
    logic [1:0]  nxt_mode;
    logic [4:0]  nxt_rt;
    logic        nxt_fused;

    assign out_free = !vld_p1 || bus.out_ready;

`ifdef IMM_FUSE_EN
    ctrl_state_e state_q, state_d;
    logic [15:0] lui_imm_q;
    logic [4:0]  lui_rt_q;
    logic        hold_lui;
    logic        ori_match;

    assign ori_match = (opcode == OP_ORI) && (bus.in_instr[25:21] == lui_rt_q)
                       && (rt == lui_rt_q);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        load      = 1'b0;
        hold_lui  = 1'b0;
        nxt_imm   = ext_imm;
        nxt_mode  = ext_mode;
        nxt_rt    = rt;
        nxt_fused = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = out_free;
                if (bus.in_valid && out_free) begin
                    if (opcode == OP_LUI) begin
                        hold_lui = 1'b1;
                        state_d  = ST_HOLD_LUI;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ST_HOLD_LUI: begin
                // A non-matching instruction is left waiting; it flushes the held lui out.
                if (bus.in_valid) begin
                    in_ready = ori_match && out_free;
                    nxt_rt   = lui_rt_q;
                    nxt_mode = MODE_UPPER;
                    if (out_free) begin
                        load    = 1'b1;
                        state_d = ST_IDLE;
                        if (ori_match) begin
                            nxt_imm   = {lui_imm_q, imm16};
                            nxt_fused = 1'b1;
                        end else begin
                            nxt_imm   = {lui_imm_q, 16'h0000};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) in_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (hold_lui) begin
            lui_imm_q <= imm16;
            lui_rt_q  <= rt;
        end
    end
`else
    always_comb begin
        in_ready  = out_free && !rst;
        load      = bus.in_valid && in_ready;
        nxt_imm   = ext_imm;
        nxt_mode  = ext_mode;
        nxt_rt    = rt;
        nxt_fused = 1'b0;
    end
`endif

    // ---- output register stage (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            imm_p1   <= 32'h0000_0000;
            mode_p1  <= MODE_ZERO;
            rt_p1    <= 5'd0;
            fused_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
        end else if (load) begin
            vld_p1   <= 1'b1;
            imm_p1   <= nxt_imm;
            mode_p1  <= nxt_mode;
            rt_p1    <= nxt_rt;
            fused_p1 <= nxt_fused;
        end else if (bus.out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_imm   = imm_p1;
    assign bus.out_mode  = mode_p1;
    assign bus.out_rt    = rt_p1;
    assign bus.out_fused = fused_p1;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Directed bench for imm_ext_ctrl; fusion scenarios run when IMM_FUSE_EN is defined.
module tb_imm_ext_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_chk  = 0;
    int   n_fail = 0;

    imm_ext_ctrl_if bus ();

    imm_ext_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic v, input logic [31:0] imm,
                           input logic [1:0] mode, input logic [4:0] rt, input logic fused);
        chk({tag, "_vld"},   {31'b0, bus.out_valid}, {31'b0, v});
        chk({tag, "_imm"},   bus.out_imm, imm);
        chk({tag, "_mode"},  {30'b0, bus.out_mode}, {30'b0, mode});
        chk({tag, "_rt"},    {27'b0, bus.out_rt}, {27'b0, rt});
        chk({tag, "_fused"}, {31'b0, bus.out_fused}, {31'b0, fused});
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic send(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_instr = 32'h0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        tick();
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        exp_out("rst", 1'b0, 32'h0, 2'b00, 5'd0, 1'b0);
        rst = 1'b0;

        // ori -> zero extension
        send(32'h3401_8000);
        #1 chk("ori_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        exp_out("ori", 1'b1, 32'h0000_8000, 2'b00, 5'd1, 1'b0);
        send(mk(6'h08, 5'd0, 5'd2, 16'hFFFC));
        tick();
        exp_out("addi", 1'b1, 32'hFFFF_FFFC, 2'b01, 5'd2, 1'b0);
        send(mk(6'h04, 5'd1, 5'd3, 16'hFFFF));
        tick();
        exp_out("beq", 1'b1, 32'hFFFF_FFFC, 2'b11, 5'd3, 1'b0);
        send(mk(6'h23, 5'd0, 5'd7, 16'h7FFF));
        tick();
        exp_out("lw", 1'b1, 32'h0000_7FFF, 2'b01, 5'd7, 1'b0);
        send(mk(6'h3F, 5'd0, 5'd10, 16'hABCD));
        tick();
        exp_out("unk", 1'b1, 32'h0000_0000, 2'b00, 5'd10, 1'b0);
        send(mk(6'h05, 5'd0, 5'd11, 16'h0001));
        tick();
        exp_out("bne", 1'b1, 32'h0000_0004, 2'b11, 5'd11, 1'b0);
        idle();
        tick();
        chk("drain_vld", {31'b0, bus.out_valid}, 32'd0);

        // backpressure: lui result stalls, pending xori waits
        send(mk(6'h0F, 5'd0, 5'd4, 16'h1234));
        tick();
        send(mk(6'h0E, 5'd0, 5'd5, 16'h00FF));
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_out("stall", 1'b1, 32'h1234_0000, 2'b10, 5'd4, 1'b0);
            chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        #1 chk("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        exp_out("xori", 1'b1, 32'h0000_00FF, 2'b00, 5'd5, 1'b0);
        idle();
        tick();
        chk("xori_drain", {31'b0, bus.out_valid}, 32'd0);

        // flush beats a simultaneous accept
        send(mk(6'h08, 5'd0, 5'd12, 16'h0001));
        flush = 1'b1;
        tick();
        chk("flush_acc_vld", {31'b0, bus.out_valid}, 32'd0);
        flush = 1'b0;
        idle();
        tick();
        chk("flush_acc_vld2", {31'b0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;
        send(mk(6'h0C, 5'd0, 5'd13, 16'h00F0));
        tick();
        exp_out("andi", 1'b1, 32'h0000_00F0, 2'b00, 5'd13, 1'b0);
        idle();
        flush = 1'b1;
        tick();
        chk("flush_held_vld", {31'b0, bus.out_valid}, 32'd0);
        flush = 1'b0;

        // reset with a pending output
        send(mk(6'h0E, 5'd0, 5'd6, 16'h5555));
        tick();
        exp_out("pre_rst", 1'b1, 32'h0000_5555, 2'b00, 5'd6, 1'b0);
        idle();
        rst = 1'b1;
        #1 chk("rst_mid_in_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        exp_out("rst_mid", 1'b0, 32'h0, 2'b00, 5'd0, 1'b0);
        chk("rst_mid_in_ready2", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;

`ifdef IMM_FUSE_EN
        // lui+ori fusion, with the lui held across idle cycles
        send(mk(6'h0F, 5'd0, 5'd8, 16'hDEAD));
        #1 chk("lui_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        chk("hold_vld0", {31'b0, bus.out_valid}, 32'd0);
        idle();
        tick();
        chk("hold_vld1", {31'b0, bus.out_valid}, 32'd0);
        send(mk(6'h0D, 5'd8, 5'd8, 16'hBEEF));
        #1 chk("ori_fuse_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        exp_out("fused", 1'b1, 32'hDEAD_BEEF, 2'b10, 5'd8, 1'b1);
        idle();
        tick();
        chk("fused_drain", {31'b0, bus.out_valid}, 32'd0);

        // lui followed by a non-matching instruction
        send(mk(6'h0F, 5'd0, 5'd8, 16'h1000));
        tick();
        chk("hold2_vld", {31'b0, bus.out_valid}, 32'd0);
        send(mk(6'h08, 5'd0, 5'd9, 16'h0010));
        #1 chk("nomatch_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        exp_out("lui_unfused", 1'b1, 32'h1000_0000, 2'b10, 5'd8, 1'b0);
        tick();
        exp_out("addi_after", 1'b1, 32'h0000_0010, 2'b01, 5'd9, 1'b0);

        // flush while holding a lui
        send(mk(6'h0F, 5'd0, 5'd8, 16'h2222));
        tick();
        chk("hold3_vld", {31'b0, bus.out_valid}, 32'd0);
        idle();
        flush = 1'b1;
        tick();
        chk("hold_flush_vld", {31'b0, bus.out_valid}, 32'd0);
        flush = 1'b0;
        send(mk(6'h0D, 5'd8, 5'd8, 16'h0001));
        tick();
        exp_out("ori_post_flush", 1'b1, 32'h0000_0001, 2'b00, 5'd8, 1'b0);
        idle();
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_ext_ctrl.md
IMM_EXT_CTRL -- requirements
Module: imm_ext_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide: flush  input  1  discard all held and pending work.
REQ-004 SHALL provide: in_valid  input  1  in_instr is valid.
REQ-005 SHALL provide: in_ready  output  1  instruction accepted when in_valid and in_ready are both high at a clock edge.
REQ-006 SHALL provide: in_instr  input  32  MIPS instruction word; opcode [31:26], rs [25:21], rt [20:16], imm [15:0].
REQ-007 SHALL provide: out_valid  output  1  result registers hold a valid result.
REQ-008 SHALL provide: out_ready  input  1  consumer accepts the result.
REQ-009 SHALL provide: out_imm  output  32  extended immediate.
REQ-010 SHALL provide: out_mode  output  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
REQ-011 SHALL provide: out_rt  output  5  destination rt of the result.
REQ-012 SHALL provide: out_fused  output  1  result is a fused LUI+ORI constant.

Function
REQ-013 SHALL decode the extension mode from the opcode as follows:
  - zero: andi 0x0C, ori 0x0D, xori 0x0E; result {16'b0, imm}.
  - sign: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, lw 0x23, sw 0x2B; result {16{imm[15]}, imm}.
  - upper: lui 0x0F; result {imm, 16'b0}.
  - branch: beq 0x04, bne 0x05; result {14{imm[15]}, imm, 2'b00}.
REQ-014 SHALL treat any other opcode as mode 00 with out_imm = 0.
REQ-015 SHALL register results with exactly 1-cycle latency: an instruction accepted at edge N appears on the outputs after edge N.
REQ-016 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-017 SHALL drive in_ready = !out_valid || out_ready in state IDLE, so full throughput is one instruction per cycle.
REQ-018 SHALL, on a simultaneous output handshake and input accept, replace the output contents with the new result without a bubble.
REQ-019 SHALL, on flush, clear out_valid and return to IDLE at the next edge; flush SHALL override a simultaneous accept, and the instruction is dropped.
REQ-020 SHALL drive out_fused = 0 whenever fusion is compiled out.

Reset
REQ-021 SHALL, while rst=1 at an edge, set state IDLE, out_valid 0, out_imm 0, out_mode 00, out_rt 0, out_fused 0.
REQ-022 SHALL drive in_ready = 0 during reset cycles.
REQ-023 SHALL abandon any held LUI or pending output when reset asserts mid-operation, without emitting it.

Configuration
REQ-024 SHALL, with IMM_FUSE_EN defined, implement a two-state FSM with states IDLE and HOLD_LUI.
REQ-025 SHALL, in IDLE, hold an accepted lui internally with no output and move to HOLD_LUI.
REQ-026 SHALL, in HOLD_LUI, peek in_instr while in_valid=1:
  - match (ori with rs == rt == held rt): assert in_ready, accept it, emit {lui_imm, ori_imm} with mode 10, out_fused=1, then go to IDLE.
  - no match: keep in_ready=0, emit the held lui unfused once the output is free, then go to IDLE.
REQ-027 SHALL, in HOLD_LUI with in_valid=0, keep holding the lui indefinitely.
REQ-028 SHALL, with IMM_FUSE_EN undefined, have no FSM and emit lui as an ordinary upper-mode result.

Structure
REQ-029 SHALL place opcode constants, the 2-bit mode encoding, and the FSM state encoding in shared package imm_ext_pkg.
REQ-030 SHALL implement the combinational mode/extension datapath as sub-module imm_ext_unit (instr -> imm32, mode).
REQ-031 SHALL contain the handshake, output register and FSM in imm_ext_ctrl itself.

Verification
REQ-032 SHALL cover: ori 0x3401_8000 accepted, out_ready=1 -> next cycle out_imm=0x0000_8000, mode 00.
REQ-033 SHALL cover: addi imm 0xFFFC, then beq imm 0xFFFF back-to-back -> 0xFFFF_FFFC mode 01, then 0xFFFF_FFFC mode 11, no bubble.
REQ-034 SHALL cover: out_ready=0 for 3 cycles with result 0x1234_0000 -> outputs stable, in_ready=0, next result appears 1 cycle after out_ready rises.
REQ-035 SHALL cover (IMM_FUSE_EN): lui rt=8 imm 0xDEAD, then ori rs=rt=8 imm 0xBEEF -> single result 0xDEAD_BEEF, out_fused=1, out_rt=8.
REQ-036 SHALL cover (IMM_FUSE_EN): lui rt=8 imm 0x1000, then addi -> 0x1000_0000 unfused, then addi result next; also flush in HOLD_LUI -> nothing emitted.
REQ-037 SHALL cover: rst asserted while out_valid=1 -> all outputs 0 after the edge, in_ready=0 during reset.
